instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the control unit/decoder; owns the PC, issues word requests to instruction memory and delivers {instr, pc, pc_plus8} to decode.
- Variable-latency memory handshake; small instruction buffer decouples memory from decode stalls.
- Branch redirect from the execute-side PCSrc path flushes buffered and in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
BUF_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
imem_req  output  1  request valid to instruction memory
imem_addr  output  32  word-aligned fetch address, bits[1:0]=0
imem_gnt  input  1  memory accepts request this cycle (req&gnt = accepted)
imem_rvalid  input  1  read data valid
imem_rdata  input  32  instruction word
instr_valid  output  1  instr/instr_pc/pc_plus8 valid to decode
instr  output  32  instruction; NOP (32'hE1A0_0000) when instr_valid=0
instr_pc  output  32  address of instr
pc_plus8  output  32  instr_pc+8 (ARM PC-read value)
instr_ready  input  1  decode consumes entry when instr_valid&instr_ready
redirect  input  1  taken branch/PC write (PCSrc)
redirect_pc  input  32  new fetch address; bits[1:0] forced to 0

Behaviour:
- Reset (synchronous, active-high): fetch_pc=RESET_PC, buffer empty, state=FETCH, imem_req=0, instr_valid=0, instr=NOP, instr_pc=0, pc_plus8=8. imem_req may rise the first cycle after reset deasserts.
- At most one outstanding request. States (fetch_state_t):
  - FETCH: imem_req=1 iff (count + 0 in-flight) < BUF_DEPTH; on req&gnt -> WAIT, latch addr, fetch_pc+=4 (wraps 32'hFFFF_FFFC -> 0).
  - WAIT: imem_req=0; on rvalid write {rdata, addr} into buffer -> FETCH.
  - DROP: in-flight response is stale; on rvalid discard data -> FETCH.
- Redirect (highest priority, any state): buffer flushed same edge; fetch_pc=redirect_pc&~3; WAIT->DROP; FETCH with req&gnt the same cycle -> DROP (that request is stale); DROP stays DROP. instr_valid=0 in the following cycle. Redirect with rvalid the same cycle: data discarded.
- imem_addr = fetch_pc; held stable while req=1 and gnt=0.
- Buffer: FIFO, head drives instr/instr_pc/pc_plus8 (registered, 1-cycle minimum latency rvalid -> instr_valid). Push and pop in same cycle allowed when full (pop frees slot). Never pushes when full (guaranteed by request gating).
- instr_valid=1 iff buffer non-empty; outputs stable while instr_valid&~instr_ready.
- pc_plus8 = instr_pc+8 modulo 2^32.

Optional Feature:
- FETCH_BYPASS_EN defined: when buffer empty (or popping its last entry) and rvalid in WAIT with no redirect, imem_rdata drives instr combinationally with instr_valid=1 the same cycle; written to buffer only if instr_ready=0. 0-cycle fetch-to-decode latency.
- Undefined: all data passes through buffer; 1-cycle latency as above.

Decomposition:
- fetch_pkg: fetch_state_t enum {FETCH, WAIT, DROP}; ARM_NOP=32'hE1A0_0000; PC_STEP=4; PC_READ_OFS=8; fetch entry struct {instr, pc}.
- One sub-module: fetch_buffer (parameterised BUF_DEPTH FIFO, push/pop/flush, count, full/empty), synchronous reset.

Test Plan:
- Reset then gnt=1, rvalid 1 cycle after each grant, ready=1 -> imem_addr 0,4,8,...; instr_pc 0,4,8 in order, pc_plus8=instr_pc+8, no gaps beyond 1 idle cycle per fetch.
- instr_ready=0 for 10 cycles -> exactly BUF_DEPTH=2 entries buffered, imem_req=0 once full, instr/instr_pc stable at pc=0; release -> 0,4,8 delivered with none lost/duplicated.
- redirect=1, redirect_pc=32'h0000_0103 while in WAIT -> stale rvalid dropped, next imem_addr=32'h0000_0100, first delivered instr_pc=0x100, instr_valid=0 the cycle after redirect.
- imem_gnt held 0 for 5 cycles -> imem_req=1, imem_addr constant; no state change.
- redirect and rvalid coincide -> data discarded, buffer empty next cycle, fetch resumes at redirect_pc.
- RESET_PC=32'hFFFF_FFFC -> addresses FFFF_FFFC then 0000_0000; pc_plus8 of first = 0000_0004.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the instruction fetch stage.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      DROP  = 2'd2
   } fetch_state_t;

   localparam logic [31:0] ARM_NOP     = 32'hE1A0_0000;
   localparam logic [31:0] PC_STEP     = 32'd4;
   localparam logic [31:0] PC_READ_OFS = 32'd8;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Purpose  : Power-of-two FIFO of fetched {instr, pc} entries with flush.
// Revision : 1.0
// ============================================================================
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int BUF_DEPTH = 2,
   localparam int PTR_W = $clog2(BUF_DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  fetch_entry_t       push_entry,
   input  logic               pop,
   input  logic               flush,
   output fetch_entry_t       head_entry,
   output logic [CNT_W-1:0]   count,
   output logic               full,
   output logic               empty
);

   fetch_entry_t       mem_q [BUF_DEPTH];
   fetch_entry_t       mem_d [BUF_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               do_push;
   logic               do_pop;

   assign full       = (count_q == CNT_W'(BUF_DEPTH));
   assign empty      = (count_q == '0);
   assign count      = count_q;
   assign head_entry = mem_q[rd_ptr_q];

   // A pop in the same cycle frees the slot a push into a full FIFO needs.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : PC owner and single-outstanding instruction fetcher feeding decode.
//            Define FETCH_BYPASS_EN for a 0-cycle rvalid-to-decode bypass.
// Revision : 1.0
// ============================================================================
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   output logic         imem_req,
   output logic [31:0]  imem_addr,
   input  logic         imem_gnt,
   input  logic         imem_rvalid,
   input  logic [31:0]  imem_rdata,
   output logic         instr_valid,
   output logic [31:0]  instr,
   output logic [31:0]  instr_pc,
   output logic [31:0]  pc_plus8,
   input  logic         instr_ready,
   input  logic         redirect,
   input  logic [31:0]  redirect_pc
);

   localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

   fetch_state_t        state_q, state_d;
   logic [31:0]         fetch_pc_q, fetch_pc_d;
   logic [31:0]         req_addr_q, req_addr_d;

   logic                buf_push;
   logic                buf_pop;
   logic                buf_flush;
   fetch_entry_t        buf_wr_entry;
   fetch_entry_t        buf_head;
   logic [CNT_W-1:0]    buf_count;
   logic                buf_full;
   logic                buf_empty;
   logic                accept;
   logic                bypass;

   fetch_buffer #(
      .BUF_DEPTH (BUF_DEPTH)
   ) u_fetch_buffer (
      .clk        (clk),
      .reset      (reset),
      .push       (buf_push),
      .push_entry (buf_wr_entry),
      .pop        (buf_pop),
      .flush      (buf_flush),
      .head_entry (buf_head),
      .count      (buf_count),
      .full       (buf_full),
      .empty      (buf_empty)
   );

   // Nothing is in flight in FETCH, so buffer occupancy alone gates the request.
   assign imem_req  = ~reset & (state_q == FETCH) & (buf_count < CNT_W'(BUF_DEPTH));
   assign imem_addr = fetch_pc_q;
   assign accept    = imem_req & imem_gnt;

`ifdef FETCH_BYPASS_EN
   assign bypass = ~reset & (state_q == WAIT) & imem_rvalid & ~redirect & buf_empty;
`else
   assign bypass = 1'b0;
`endif

   always_comb begin
      state_d            = state_q;
      fetch_pc_d         = fetch_pc_q;
      req_addr_d         = req_addr_q;
      buf_push           = 1'b0;
      buf_flush          = 1'b0;
      buf_wr_entry.instr = imem_rdata;
      buf_wr_entry.pc    = req_addr_q;

      unique case (state_q)
         FETCH: begin
            if (accept) begin
               state_d    = WAIT;
               req_addr_d = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + PC_STEP;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               buf_push = ~buf_full | buf_pop;
               state_d  = FETCH;
            end
         end
         DROP: begin
            if (imem_rvalid) begin
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase

      if (bypass && instr_ready) begin
         buf_push = 1'b0;
      end

      // A response arriving with the redirect retires the old request, so only
      // a still-pending one needs DROP.
      if (redirect) begin
         buf_flush  = 1'b1;
         buf_push   = 1'b0;
         fetch_pc_d = word_align(redirect_pc);
         if (accept) begin
            state_d = DROP;
         end else if ((state_q != FETCH) && !imem_rvalid) begin
            state_d = DROP;
         end else begin
            state_d = FETCH;
         end
      end
   end

   always_comb begin
      instr_valid = 1'b0;
      instr       = ARM_NOP;
      instr_pc    = 32'h0000_0000;
      if (!buf_empty) begin
         instr_valid = 1'b1;
         instr       = buf_head.instr;
         instr_pc    = buf_head.pc;
      end else if (bypass) begin
         instr_valid = 1'b1;
         instr       = imem_rdata;
         instr_pc    = req_addr_q;
      end
   end

   assign pc_plus8 = instr_pc + PC_READ_OFS;
   assign buf_pop  = instr_valid & instr_ready & ~buf_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= FETCH;
         fetch_pc_q <= word_align(RESET_PC);
         req_addr_q <= word_align(RESET_PC);
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_addr_q <= req_addr_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Self-checking bench for instr_fetch_unit with a queue-based
//            delivery model and a variable-latency memory responder.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch_unit;

   localparam int          BUF_DEPTH = 2;
   localparam logic [31:0] NOP       = 32'hE1A0_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_pc;

   logic        imem_req,  w2_req;
   logic [31:0] imem_addr, w2_addr;
   logic        instr_valid, w2_valid;
   logic [31:0] instr, w2_instr;
   logic [31:0] instr_pc, w2_pc;
   logic [31:0] pc_plus8, w2_p8;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(BUF_DEPTH)) dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .pc_plus8(pc_plus8), .instr_ready(instr_ready), .redirect(redirect),
      .redirect_pc(redirect_pc)
   );

   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(BUF_DEPTH)) dut_wrap (
      .clk(clk), .reset(reset), .imem_req(w2_req), .imem_addr(w2_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(w2_valid), .instr(w2_instr), .instr_pc(w2_pc),
      .pc_plus8(w2_p8), .instr_ready(instr_ready), .redirect(redirect),
      .redirect_pc(redirect_pc)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Model: every accepted request not superseded by a redirect is delivered
   // exactly once, in order. Queue holds granted-but-undelivered addresses.
   logic [31:0] exp_q[$];
   bit          busy, live;
   int          lat_cnt, lat;
   logic [31:0] mem_addr, model_pc;
   bit          gnt_en, ready_en;
   int          redir_mode;
   logic [31:0] redir_pc, lit_pc;
   bit          after_redirect, hold_prev, lit_grant_pend, lit_deliv_pend, ever_redirected;
   logic [31:0] prev_addr;
   int          grant_idx, deliver_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] memf(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic step();
      bit acc, fire, exp_valid, exp_req;
      #1;
      exp_valid = (exp_q.size() - int'(live)) > 0;
      exp_req   = !busy && (exp_q.size() < BUF_DEPTH);
      chk("instr_valid", 32'(instr_valid), 32'(exp_valid));
      if (!instr_valid) chk("instr_nop", instr, NOP);
      chk("imem_req", 32'(imem_req), 32'(exp_req));
      if (imem_req) chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
      if (hold_prev) chk("addr_hold", imem_addr, prev_addr);
      if (after_redirect) chk("valid_after_redirect", 32'(instr_valid), 32'd0);
      after_redirect = 1'b0;
      if (!ever_redirected) begin
         chk("wrap_valid", 32'(w2_valid), 32'(exp_valid));
         chk("wrap_req", 32'(w2_req), 32'(exp_req));
      end

      imem_rvalid = busy && (lat_cnt == 0);
      imem_rdata  = imem_rvalid ? memf(mem_addr) : $urandom;
      imem_gnt    = gnt_en;
      instr_ready = ready_en;
      case (redir_mode)
         1:       fire = busy && live && !imem_rvalid;
         2:       fire = imem_rvalid && live;
         3:       fire = imem_req && imem_gnt;
         default: fire = 1'b0;
      endcase
      redirect    = fire;
      redirect_pc = fire ? redir_pc : $urandom;

      acc = imem_req && imem_gnt;
      if (instr_valid && instr_ready && exp_q.size() > 0) begin
         chk("deliver_pc", instr_pc, exp_q[0]);
         chk("deliver_instr", instr, memf(exp_q[0]));
         chk("deliver_pc_plus8", pc_plus8, exp_q[0] + 32'd8);
         if (!ever_redirected) begin
            case (deliver_cnt)
               0: begin
                  chk("first_pc", instr_pc, 32'h0000_0000);
                  chk("first_pc_plus8", pc_plus8, 32'h0000_0008);
                  chk("wrap_first_pc", w2_pc, 32'hFFFF_FFFC);
                  chk("wrap_first_pc_plus8", w2_p8, 32'h0000_0004);
               end
               1: begin
                  chk("second_pc", instr_pc, 32'h0000_0004);
                  chk("wrap_second_pc", w2_pc, 32'h0000_0000);
                  chk("wrap_second_pc_plus8", w2_p8, 32'h0000_0008);
               end
               2: chk("third_pc", instr_pc, 32'h0000_0008);
               default: ;
            endcase
         end
         if (lit_deliv_pend) begin
            chk("redirect_first_pc", instr_pc, lit_pc);
            lit_deliv_pend = 1'b0;
         end
         void'(exp_q.pop_front());
         deliver_cnt++;
      end

      if (acc) begin
         chk("fetch_addr", imem_addr, model_pc);
         if (!ever_redirected && grant_idx == 0) begin
            chk("addr0", imem_addr, 32'h0000_0000);
            chk("wrap_addr0", w2_addr, 32'hFFFF_FFFC);
         end
         if (!ever_redirected && grant_idx == 1) begin
            chk("addr1", imem_addr, 32'h0000_0004);
            chk("wrap_addr1", w2_addr, 32'h0000_0000);
         end
         grant_idx++;
         if (lit_grant_pend) begin
            chk("redirect_addr", imem_addr, lit_pc);
            lit_grant_pend = 1'b0;
         end
      end

      if (imem_rvalid) begin
         busy = 1'b0;
         live = 1'b0;
      end else if (busy) begin
         lat_cnt--;
      end
      if (acc) begin
         busy     = 1'b1;
         lat_cnt  = lat;
         mem_addr = imem_addr;
      end
      if (fire) begin
         exp_q.delete();
         live            = 1'b0;
         model_pc        = redir_pc & ~32'h3;
         after_redirect  = 1'b1;
         ever_redirected = 1'b1;
         redir_mode      = 0;
         lit_grant_pend  = 1'b1;
         lit_deliv_pend  = 1'b1;
      end else if (acc) begin
         exp_q.push_back(imem_addr);
         live     = 1'b1;
         model_pc = model_pc + 32'd4;
      end
      hold_prev = imem_req && !imem_gnt && !fire;
      prev_addr = imem_addr;
      @(negedge clk);
   endtask

   task automatic fire_redirect(input int mode, input logic [31:0] pc, input logic [31:0] lit, input string name);
      int budget;
      redir_mode = mode;
      redir_pc   = pc;
      lit_pc     = lit;
      budget     = 40;
      while (redir_mode != 0 && budget > 0) begin
         step();
         budget--;
      end
      if (redir_mode != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: redirect condition not reached, got timeout expected trigger", name);
         redir_mode = 0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
      busy = 0; live = 0; lat = 0; lat_cnt = 0; mem_addr = '0; model_pc = 32'h0;
      gnt_en = 1; ready_en = 1; redir_mode = 0; redir_pc = '0; lit_pc = '0;
      after_redirect = 0; hold_prev = 0; lit_grant_pend = 0; lit_deliv_pend = 0;
      ever_redirected = 0; prev_addr = '0; grant_idx = 0; deliver_cnt = 0;

      repeat (3) @(negedge clk);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, NOP);
      chk("rst_pc", instr_pc, 32'h0);
      chk("rst_pc_plus8", pc_plus8, 32'h8);
      chk("wrap_rst_pc_plus8", w2_p8, 32'h8);
      reset = 1'b0;

      // Streaming, grant always, 1-cycle memory latency, decode always ready.
      repeat (20) step();
      chk("throughput", 32'(deliver_cnt >= 9), 32'd1);

      // Decode stall: buffer fills and requests stop.
      ready_en = 0;
      repeat (10) step();
      chk("stall_buffered", 32'(exp_q.size()), 32'd2);
      chk("stall_req_low", 32'(imem_req), 32'd0);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      ready_en = 1;
      repeat (10) step();

      // Redirect while waiting on memory; the stale response must vanish.
      lat = 2;
      fire_redirect(1, 32'h0000_0103, 32'h0000_0100, "redirect_wait");
      repeat (12) step();

      // Grant withheld: request and address must hold.
      gnt_en = 0;
      repeat (6) step();
      chk("gnt_hold_req", 32'(imem_req), 32'd1);
      chk("gnt_hold_addr", imem_addr, prev_addr);
      gnt_en = 1;
      repeat (8) step();

      // Redirect coinciding with read data.
      lat = 0;
      fire_redirect(2, 32'h0000_0202, 32'h0000_0200, "redirect_rvalid");
      repeat (10) step();

      // Redirect in the same cycle as a grant.
      lat = 1;
      fire_redirect(3, 32'h0000_030F, 32'h0000_030C, "redirect_grant");
      repeat (10) step();

      // Intermittent decode readiness.
      for (int i = 0; i < 16; i++) begin
         ready_en = (i % 3) != 0;
         step();
      end

      // Drain.
      ready_en = 1;
      gnt_en   = 0;
      repeat (10) step();
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
      chk("drain_valid", 32'(instr_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
